// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks the PC through instruction memory one word at a
// time, presents the fetched word and PC+4 to the IF/ID register, and handles
// redirects, including ones that arrive while a request is still outstanding.
// Optional feature macro: FETCH_MISALIGN_EN (misaligned-redirect fault + HALT).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] q_nextPC,
  output logic [31:0] q_instruction,
  output logic        valid
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        fault
`endif
);

`ifdef FETCH_MISALIGN_EN
  typedef enum logic [2:0] {StIdle, StReq, StHold, StDrain, StHalt} state_e;
`else
  typedef enum logic [1:0] {StIdle, StReq, StHold, StDrain} state_e;
`endif

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] tgt_q;
  logic        req_q;
  logic        valid_q;
  logic [31:0] nextpc_q;
  logic [31:0] instr_q;

  logic [31:0] br_tgt;
  logic [31:0] drain_tgt;

`ifdef FETCH_MISALIGN_EN
  logic        fault_q;
  logic        tgt_bad_q;
  logic        br_bad;
  logic        drain_bad;
`endif

  // Redirect target as used by the PC; the newest redirect wins on the closing drain ack.
  always_comb begin
`ifdef FETCH_MISALIGN_EN
    br_tgt    = br_target;
    br_bad    = |br_target[1:0];
    drain_bad = br_taken ? br_bad : tgt_bad_q;
`else
    br_tgt    = {br_target[31:2], 2'b00};
`endif
    drain_tgt = br_taken ? br_tgt : tgt_q;
  end

  // Fetch FSM with registered request, data and valid outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      tgt_q    <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      nextpc_q <= '0;
      instr_q  <= '0;
`ifdef FETCH_MISALIGN_EN
      fault_q   <= 1'b0;
      tgt_bad_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
`ifdef FETCH_MISALIGN_EN
          if (br_taken && br_bad) begin
            fault_q <= 1'b1;
            state_q <= StHalt;
          end else
`endif
          begin
            if (br_taken) pc_q <= br_tgt;
            req_q   <= 1'b1;
            state_q <= StReq;
          end
        end

        StReq: begin
          if (br_taken && imem_ack) begin
            // Returned word belongs to the wrong path: drop it and refetch.
`ifdef FETCH_MISALIGN_EN
            if (br_bad) begin
              fault_q <= 1'b1;
              req_q   <= 1'b0;
              state_q <= StHalt;
            end else
`endif
            pc_q <= br_tgt;
          end else if (br_taken) begin
            // Request must stay stable until acked, so park the target.
            tgt_q   <= br_tgt;
            state_q <= StDrain;
`ifdef FETCH_MISALIGN_EN
            tgt_bad_q <= br_bad;
`endif
          end else if (imem_ack) begin
            instr_q  <= imem_rdata;
            nextpc_q <= pc_q + 32'd4;
            valid_q  <= 1'b1;
            req_q    <= 1'b0;
            state_q  <= StHold;
          end
        end

        StDrain: begin
          if (imem_ack) begin
`ifdef FETCH_MISALIGN_EN
            if (drain_bad) begin
              fault_q <= 1'b1;
              req_q   <= 1'b0;
              state_q <= StHalt;
            end else
`endif
            begin
              pc_q    <= drain_tgt;
              state_q <= StReq;
            end
          end else if (br_taken) begin
            tgt_q <= br_tgt;
`ifdef FETCH_MISALIGN_EN
            tgt_bad_q <= br_bad;
`endif
          end
        end

        StHold: begin
          if (br_taken) begin
            valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_EN
            if (br_bad) begin
              fault_q <= 1'b1;
              state_q <= StHalt;
            end else
`endif
            begin
              pc_q    <= br_tgt;
              req_q   <= 1'b1;
              state_q <= StReq;
            end
          end else if (!stall) begin
            pc_q    <= pc_q + 32'd4;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= StReq;
          end
        end

`ifdef FETCH_MISALIGN_EN
        StHalt: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
`endif

        default: state_q <= StIdle;
      endcase
    end
  end

  // In DRAIN the PC still holds the abandoned address, keeping imem_addr stable.
  assign imem_req      = req_q;
  assign imem_addr     = pc_q;
  assign q_nextPC      = nextpc_q;
  assign q_instruction = instr_q;
  assign valid         = valid_q;
`ifdef FETCH_MISALIGN_EN
  assign fault         = fault_q;
`endif

endmodule
